// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: widths and the ControlUnit control bundle.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ALUCTRL_W    = 3;
  localparam int unsigned REG_ADDR_W   = 5;

  typedef struct packed {
    logic                 RegisterWrite;
    logic                 ALUSourceSelect;
    logic                 MemoryWrite;
    logic                 ResultSourceSelect;
    logic                 Branch;
    logic [ALUCTRL_W-1:0] ALUcontrol;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary signals; master = decode side, slave = the ID/EX stage.
interface id_ex_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 16
);

  logic                  d_valid;
  logic                  d_RegisterWrite;
  logic                  d_ALUSourceSelect;
  logic                  d_MemoryWrite;
  logic                  d_ResultSourceSelect;
  logic                  d_Branch;
  logic [ALUCTRL_W-1:0]  d_ALUcontrol;
  logic [REG_ADDR_W-1:0] d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0]       d_rs1_data, d_rs2_data, d_imm, d_pc, d_pc_plus4;
  logic                  flush_e;

  logic                  e_valid;
  logic                  e_RegisterWrite;
  logic                  e_ALUSourceSelect;
  logic                  e_MemoryWrite;
  logic                  e_ResultSourceSelect;
  logic                  e_Branch;
  logic [ALUCTRL_W-1:0]  e_ALUcontrol;
  logic [REG_ADDR_W-1:0] e_rs1, e_rs2, e_rd;
  logic [XLEN-1:0]       e_rs1_data, e_rs2_data, e_imm, e_pc, e_pc_plus4;
  logic                  stall_fd;
  logic [CNT_W-1:0]      stall_count, flush_count;

  modport master (
    output d_valid, d_RegisterWrite, d_ALUSourceSelect, d_MemoryWrite, d_ResultSourceSelect,
           d_Branch, d_ALUcontrol, d_rs1, d_rs2, d_rd, d_rs1_data, d_rs2_data, d_imm, d_pc,
           d_pc_plus4, flush_e,
    input  e_valid, e_RegisterWrite, e_ALUSourceSelect, e_MemoryWrite, e_ResultSourceSelect,
           e_Branch, e_ALUcontrol, e_rs1, e_rs2, e_rd, e_rs1_data, e_rs2_data, e_imm, e_pc,
           e_pc_plus4, stall_fd, stall_count, flush_count
  );

  modport slave (
    input  d_valid, d_RegisterWrite, d_ALUSourceSelect, d_MemoryWrite, d_ResultSourceSelect,
           d_Branch, d_ALUcontrol, d_rs1, d_rs2, d_rd, d_rs1_data, d_rs2_data, d_imm, d_pc,
           d_pc_plus4, flush_e,
    output e_valid, e_RegisterWrite, e_ALUSourceSelect, e_MemoryWrite, e_ResultSourceSelect,
           e_Branch, e_ALUcontrol, e_rs1, e_rs2, e_rd, e_rs1_data, e_rs2_data, e_imm, e_pc,
           e_pc_plus4, stall_fd, stall_count, flush_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: the load in execute writes a register the decode instruction reads.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic                  e_valid,
  input  logic                  e_load,
  input  logic                  e_reg_write,
  input  logic [REG_ADDR_W-1:0] e_rd,
  input  logic                  d_valid,
  input  logic                  d_mem_write,
  input  logic                  d_branch,
  input  logic                  d_alu_src,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  output logic                  hazard
);

  logic uses_rs2;

  // rs2 is only a real source for stores, branches and reg-reg ALU ops
  assign uses_rs2 = d_mem_write | d_branch | ~d_alu_src;

  assign hazard = e_valid & e_load & e_reg_write & (e_rd != '0) & d_valid &
                  ((e_rd == d_rs1) | ((e_rd == d_rs2) & uses_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and saturating event counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  ctrl_bundle_t          d_ctrl, e_ctrl;
  logic                  e_valid, hazard, stall;
  logic [REG_ADDR_W-1:0] e_rs1, e_rs2, e_rd;
  logic [XLEN-1:0]       e_rs1_data, e_rs2_data, e_imm, e_pc, e_pc_plus4;
  logic [CNT_W-1:0]      stall_count, flush_count;

  always_comb begin
    d_ctrl                    = CTRL_BUBBLE;
    d_ctrl.RegisterWrite      = bus.d_RegisterWrite;
    d_ctrl.ALUSourceSelect    = bus.d_ALUSourceSelect;
    d_ctrl.MemoryWrite        = bus.d_MemoryWrite;
    d_ctrl.ResultSourceSelect = bus.d_ResultSourceSelect;
    d_ctrl.Branch             = bus.d_Branch;
    d_ctrl.ALUcontrol         = bus.d_ALUcontrol;
  end

  load_use_detect u_load_use_detect (
    .e_valid     (e_valid),
    .e_load      (e_ctrl.ResultSourceSelect),
    .e_reg_write (e_ctrl.RegisterWrite),
    .e_rd        (e_rd),
    .d_valid     (bus.d_valid),
    .d_mem_write (bus.d_MemoryWrite),
    .d_branch    (bus.d_Branch),
    .d_alu_src   (bus.d_ALUSourceSelect),
    .d_rs1       (bus.d_rs1),
    .d_rs2       (bus.d_rs2),
    .hazard      (hazard)
  );

  // Flush only masks the stall output; the hazard compare never sees flush_e
  assign stall = hazard & ~bus.flush_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid     <= 1'b0;
      e_ctrl      <= CTRL_BUBBLE;
      e_rs1       <= '0;
      e_rs2       <= '0;
      e_rd        <= '0;
      e_rs1_data  <= '0;
      e_rs2_data  <= '0;
      e_imm       <= '0;
      e_pc        <= '0;
      e_pc_plus4  <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (bus.flush_e || hazard) begin
        e_valid <= 1'b0;
        e_ctrl  <= CTRL_BUBBLE;
      end else begin
        e_valid    <= bus.d_valid;
        e_ctrl     <= bus.d_valid ? d_ctrl : CTRL_BUBBLE;
        e_rs1      <= bus.d_rs1;
        e_rs2      <= bus.d_rs2;
        e_rd       <= bus.d_rd;
        e_rs1_data <= bus.d_rs1_data;
        e_rs2_data <= bus.d_rs2_data;
        e_imm      <= bus.d_imm;
        e_pc       <= bus.d_pc;
        e_pc_plus4 <= bus.d_pc_plus4;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (bus.flush_e && bus.d_valid && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign bus.e_valid              = e_valid;
  assign bus.e_RegisterWrite      = e_ctrl.RegisterWrite;
  assign bus.e_ALUSourceSelect    = e_ctrl.ALUSourceSelect;
  assign bus.e_MemoryWrite        = e_ctrl.MemoryWrite;
  assign bus.e_ResultSourceSelect = e_ctrl.ResultSourceSelect;
  assign bus.e_Branch             = e_ctrl.Branch;
  assign bus.e_ALUcontrol         = e_ctrl.ALUcontrol;
  assign bus.e_rs1                = e_rs1;
  assign bus.e_rs2                = e_rs2;
  assign bus.e_rd                 = e_rd;
  assign bus.e_rs1_data           = e_rs1_data;
  assign bus.e_rs2_data           = e_rs2_data;
  assign bus.e_imm                = e_imm;
  assign bus.e_pc                 = e_pc;
  assign bus.e_pc_plus4           = e_pc_plus4;
  assign bus.stall_fd             = stall;
  assign bus.stall_count          = stall_count;
  assign bus.flush_count          = flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the pipeline/hazard flow, hand sequences for reset and saturation.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  // control byte: {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUcontrol[2:0]}
  localparam logic [7:0] C_ADD  = 8'h82;
  localparam logic [7:0] C_LW   = 8'hD2;
  localparam logic [7:0] C_ADDI = 8'hC2;
  localparam logic [7:0] C_SW   = 8'h62;
  localparam logic [7:0] C_NONE = 8'h00;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) ifc ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic       valid;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       flush;
    logic       exp_stall;
    logic       exp_ev;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic v, logic [7:0] c, logic [4:0] s1, logic [4:0] s2,
                              logic [4:0] d, logic f, logic es, logic ev, logic [7:0] ec);
    vec_t r;
    r.valid = v; r.ctrl = c; r.rs1 = s1; r.rs2 = s2; r.rd = d; r.flush = f;
    r.exp_stall = es; r.exp_ev = ev; r.exp_ctrl = ec;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] c, logic [4:0] s1, logic [4:0] s2,
                       logic [4:0] d, logic f, int tag);
    ifc.d_valid              = v;
    ifc.d_RegisterWrite      = c[7];
    ifc.d_ALUSourceSelect    = c[6];
    ifc.d_MemoryWrite        = c[5];
    ifc.d_ResultSourceSelect = c[4];
    ifc.d_Branch             = c[3];
    ifc.d_ALUcontrol         = c[2:0];
    ifc.d_rs1                = s1;
    ifc.d_rs2                = s2;
    ifc.d_rd                 = d;
    ifc.flush_e              = f;
    ifc.d_rs1_data           = 32'h1111_0000 + 32'(tag);
    ifc.d_rs2_data           = 32'h2222_0000 + 32'(tag);
    ifc.d_imm                = 32'hFFFF_F000 | 32'(tag);
    ifc.d_pc                 = 32'h0000_1000 + 32'(tag * 4);
    ifc.d_pc_plus4           = 32'h0000_1004 + 32'(tag * 4);
  endtask

  function automatic logic [7:0] e_ctrl_byte();
    return {ifc.e_RegisterWrite, ifc.e_ALUSourceSelect, ifc.e_MemoryWrite,
            ifc.e_ResultSourceSelect, ifc.e_Branch, ifc.e_ALUcontrol};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pipeline walk: pass-through, load-use, no-false-hazard, flush-vs-hazard, invalid capture
    vecs[0]  = mk(1, C_ADD,  1, 2, 3, 0, 0, 1, C_ADD);   // add x3,x1,x2
    vecs[1]  = mk(1, C_LW,   1, 0, 5, 0, 0, 1, C_LW);    // lw x5
    vecs[2]  = mk(1, C_ADD,  5, 7, 6, 0, 1, 0, C_NONE);  // add x6,x5,x7 -> stall
    vecs[3]  = mk(1, C_ADD,  5, 7, 6, 0, 0, 1, C_ADD);   // held add captured
    vecs[4]  = mk(1, C_LW,   1, 0, 0, 0, 0, 1, C_LW);    // lw x0
    vecs[5]  = mk(1, C_ADD,  0, 0, 6, 0, 0, 1, C_ADD);   // use x0: no hazard
    vecs[6]  = mk(1, C_LW,   1, 0, 5, 0, 0, 1, C_LW);    // lw x5
    vecs[7]  = mk(1, C_ADDI, 4, 5, 6, 0, 0, 1, C_ADDI);  // addi, rs2 field=5 unused
    vecs[8]  = mk(1, C_LW,   1, 0, 5, 0, 0, 1, C_LW);    // lw x5
    vecs[9]  = mk(1, C_SW,   2, 5, 0, 0, 1, 0, C_NONE);  // sw x5 -> stall via rs2
    vecs[10] = mk(1, C_SW,   2, 5, 0, 0, 0, 1, C_SW);
    vecs[11] = mk(1, C_LW,   1, 0, 5, 0, 0, 1, C_LW);    // lw x5
    vecs[12] = mk(1, C_ADD,  5, 7, 6, 1, 0, 0, C_NONE);  // flush beats hazard
    vecs[13] = mk(1, C_LW,   1, 0, 5, 0, 0, 1, C_LW);    // lw x5
    vecs[14] = mk(0, C_ADD,  5, 7, 6, 0, 0, 0, C_NONE);  // invalid dependent: no stall, ctrl forced 0
    vecs[15] = mk(0, C_ADD,  1, 2, 3, 1, 0, 0, C_NONE);  // flush with invalid slot: not counted

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), int'($urandom_range(0, 255)));
      step();
    end
    chk("reset_e_valid", 64'(ifc.e_valid), 64'd0);
    chk("reset_e_ctrl", 64'(e_ctrl_byte()), 64'd0);
    chk("reset_stall_count", 64'(ifc.stall_count), 64'd0);
    chk("reset_flush_count", 64'(ifc.flush_count), 64'd0);
    chk("reset_e_rd", 64'(ifc.e_rd), 64'd0);
    chk("reset_e_rs1_data", 64'(ifc.e_rs1_data), 64'd0);
    chk("reset_e_pc", 64'(ifc.e_pc), 64'd0);
    reset = 1'b0;
    drive(0, C_NONE, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall_fd", 64'(ifc.stall_fd), 64'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].flush, i);
      #1;
      chk($sformatf("v%0d_stall_fd", i), 64'(ifc.stall_fd), 64'(vecs[i].exp_stall));
      step();
      chk($sformatf("v%0d_e_valid", i), 64'(ifc.e_valid), 64'(vecs[i].exp_ev));
      chk($sformatf("v%0d_e_ctrl", i), 64'(e_ctrl_byte()), 64'(vecs[i].exp_ctrl));
      if (vecs[i].exp_ev) begin
        chk($sformatf("v%0d_e_regs", i), 64'({ifc.e_rs1, ifc.e_rs2, ifc.e_rd}),
            64'({vecs[i].rs1, vecs[i].rs2, vecs[i].rd}));
        chk($sformatf("v%0d_e_rs1_data", i), 64'(ifc.e_rs1_data), 64'(32'h1111_0000 + 32'(i)));
        chk($sformatf("v%0d_e_rs2_data", i), 64'(ifc.e_rs2_data), 64'(32'h2222_0000 + 32'(i)));
        chk($sformatf("v%0d_e_imm", i), 64'(ifc.e_imm), 64'(32'hFFFF_F000 | 32'(i)));
        chk($sformatf("v%0d_e_pc", i), 64'(ifc.e_pc), 64'(32'h0000_1000 + 32'(i * 4)));
        chk($sformatf("v%0d_e_pc_plus4", i), 64'(ifc.e_pc_plus4), 64'(32'h0000_1004 + 32'(i * 4)));
      end
      if (i == 2)
        chk("after_first_stall_count", 64'(ifc.stall_count), 64'd1);
      if (i == 12)
        chk("after_flush_count", 64'(ifc.flush_count), 64'd1);
    end
    chk("table_stall_count", 64'(ifc.stall_count), 64'd2);
    chk("table_flush_count", 64'(ifc.flush_count), 64'd1);

    // reset asserted while a stall is active
    drive(1, C_LW, 1, 0, 5, 0, 40);
    step();
    drive(1, C_ADD, 5, 7, 6, 0, 41);
    #1;
    chk("midstall_stall_fd_before", 64'(ifc.stall_fd), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midstall_e_valid", 64'(ifc.e_valid), 64'd0);
    chk("midstall_e_ctrl", 64'(e_ctrl_byte()), 64'd0);
    chk("midstall_stall_count", 64'(ifc.stall_count), 64'd0);
    chk("midstall_flush_count", 64'(ifc.flush_count), 64'd0);
    chk("midstall_stall_fd_after", 64'(ifc.stall_fd), 64'd0);

    // 20 stalls into a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      drive(1, C_LW, 1, 0, 5, 0, 50);
      step();
      drive(1, C_ADD, 5, 7, 6, 0, 51);
      #1;
      if (k == 0)
        chk("sat_stall_fd", 64'(ifc.stall_fd), 64'd1);
      step();
      if (k == 13)
        chk("sat_stall_count_14", 64'(ifc.stall_count), 64'd14);
    end
    chk("sat_stall_count", 64'(ifc.stall_count), 64'd15);

    // 20 valid flushes into a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      drive(1, C_ADD, 1, 2, 3, 1, 60);
      step();
    end
    chk("sat_flush_count", 64'(ifc.flush_count), 64'd15);
    chk("sat_flush_e_valid", 64'(ifc.e_valid), 64'd0);
    chk("sat_stall_count_held", 64'(ifc.stall_count), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
